// File: rtl/and_16.sv
// rtl/and_16.sv - 16-bit bitwise AND with zero flag and optional registered copy (AND_16_REG_EN)
module and_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic [WIDTH-1:0] out_q,
    output logic             zr_q
);

    // Combinational result and zero flag, zero latency
    always_comb begin
        out = a & b;
        zr  = ~|(a & b);
    end

`ifdef AND_16_REG_EN
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic             zero_d;
    logic             zero_q;

    // Next-state for the pipeline copy: reset wins over en, en=0 holds
    always_comb begin
        res_d  = res_q;
        zero_d = zero_q;
        if (reset) begin
            res_d  = '0;
            zero_d = 1'b1;
        end else if (en) begin
            res_d  = a & b;
            zero_d = ~|(a & b);
        end
    end

    // Pipeline register with synchronous active-high reset folded into res_d/zero_d
    always_ff @(posedge clk) begin
        res_q  <= res_d;
        zero_q <= zero_d;
    end

    assign out_q = res_q;
    assign zr_q  = zero_q;
`else
    // Without the registered stage the copy is a plain wire; clk/reset/en are ignored
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset, en};

    assign out_q = out;
    assign zr_q  = zr;
`endif

endmodule

// File: tb/tb_and_16.sv
// tb/tb_and_16.sv - table-driven self-checking bench for and_16
module tb_and_16;

    logic        clk;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic        en;
    logic [15:0] out;
    logic        zr;
    logic [15:0] out_q;
    logic        zr_q;

    int checks;
    int errors;

    and_16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .en    (en),
        .out   (out),
        .zr    (zr),
        .out_q (out_q),
        .zr_q  (zr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_out;
        logic        exp_zr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        en     = 1'b0;
        a      = 16'h0000;
        b      = 16'h0000;

        vecs[0] = '{16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h5678, 16'h1230, 1'b0};
        vecs[2] = '{16'hAAAA, 16'h5555, 16'h0000, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[4] = '{16'h0F0F, 16'h00FF, 16'h000F, 1'b0};
        vecs[5] = '{16'h8001, 16'h8000, 16'h8000, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[7] = '{16'hC3C3, 16'h3C3C, 16'h0000, 1'b1};

        // Combinational table, clock running and en toggling to show no dependence
        for (int i = 0; i < 8; i++) begin
            a  = vecs[i].a;
            b  = vecs[i].b;
            en = i[0];
            #10;
            chk16($sformatf("tbl_out[%0d]", i), out, vecs[i].exp_out);
            chk1($sformatf("tbl_zr[%0d]", i), zr, vecs[i].exp_zr);
            chk16($sformatf("tbl_and[%0d]", i), out, vecs[i].a & vecs[i].b);
        end

        // Per-bit walk
        for (int i = 0; i < 16; i++) begin
            logic [15:0] one_hot;
            one_hot = 16'h0001 << i;
            a = one_hot;
            b = 16'hFFFF;
            #10;
            chk16($sformatf("walk_out[%0d]", i), out, one_hot);
            chk1($sformatf("walk_zr[%0d]", i), zr, 1'b0);
        end

`ifdef AND_16_REG_EN
        // Reset overrides en even with non-zero operands
        @(negedge clk);
        reset = 1'b1; en = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        chk16("reset_out_q", out_q, 16'h0000);
        chk1("reset_zr_q", zr_q, 1'b1);

        // Load 1230 after one edge
        @(negedge clk);
        reset = 1'b0; en = 1'b1; a = 16'h1234; b = 16'h5678;
        #1;
        chk16("pre_edge_out_q", out_q, 16'h0000);
        @(posedge clk); #1;
        chk16("load_out_q", out_q, 16'h1230);
        chk1("load_zr_q", zr_q, 1'b0);

        // Hold with en=0 while combinational path moves
        @(negedge clk);
        en = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk16("hold_out_q", out_q, 16'h1230);
        chk1("hold_zr_q", zr_q, 1'b0);
        chk16("hold_out", out, 16'hFFFF);

        // Load a zero result
        @(negedge clk);
        en = 1'b1; a = 16'hAAAA; b = 16'h5555;
        @(posedge clk); #1;
        chk16("zero_out_q", out_q, 16'h0000);
        chk1("zero_zr_q", zr_q, 1'b1);

        // Load FFFF then reset mid-stream clears on next edge
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        chk16("ffff_out_q", out_q, 16'hFFFF);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk16("midreset_out_q", out_q, 16'h0000);
        chk1("midreset_zr_q", zr_q, 1'b1);
        reset = 1'b0; en = 1'b0;
`else
        // Without the registered stage, out_q/zr_q follow inputs with no edge
        @(negedge clk);
        reset = 1'b1; en = 1'b0; a = 16'h1234; b = 16'h5678;
        #1;
        chk16("comb_out_q", out_q, 16'h1230);
        chk1("comb_zr_q", zr_q, 1'b0);
        a = 16'hAAAA; b = 16'h5555;
        #1;
        chk16("comb_out_q_zero", out_q, 16'h0000);
        chk1("comb_zr_q_zero", zr_q, 1'b1);
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF;
        #1;
        chk16("comb_out_q_ffff", out_q, 16'hFFFF);
        chk1("comb_zr_q_ffff", zr_q, 1'b0);
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
